// File: rtl/eth_rx_frame_buffer_pkg.sv
// Shared types for the MAC receive frame buffer: RX bus word and reader FSM states.
package eth_rx_frame_buffer_pkg;

  localparam int unsigned RX_WORD_BYTES = 4;

  typedef struct packed {
    logic        start;
    logic        data_valid;
    logic [2:0]  bytes_valid;
    logic [31:0] data;
    logic        commit;
    logic        drop;
  } eth_rx_bus_t;

  typedef enum logic [1:0] {RdIdle, RdFetch, RdData} rd_state_t;

endpackage

// File: rtl/eth_rx_len_fifo.sv
// Synchronous FIFO of committed frame byte lengths; pop data is shown combinationally at the head.
module eth_rx_len_fifo #(
  parameter int unsigned FRAME_SLOTS = 32,
  parameter int unsigned LEN_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push_i,
  input  logic [LEN_WIDTH-1:0] data_i,
  input  logic                 pop_i,
  output logic [LEN_WIDTH-1:0] data_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int unsigned SlotW = $clog2(FRAME_SLOTS);
  localparam int unsigned CntW  = SlotW + 1;

  logic [LEN_WIDTH-1:0] slots [FRAME_SLOTS];
  logic [SlotW-1:0]     wptr_q, rptr_q;
  logic [CntW-1:0]      count_q, count_d;
  logic                 do_push, do_pop;

  assign full_o  = (count_q == CntW'(FRAME_SLOTS));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = slots[rptr_q];

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) slots[wptr_q] <= data_i;
  end

endmodule

// File: rtl/eth_rx_frame_buffer.sv
// MAC RX frame buffer: holds words tentatively until commit/drop, replays committed frames.
// Defining ETH_RX_FRAME_BUFFER_STATS_EN adds saturating committed/dropped/overflow counters.
module eth_rx_frame_buffer
  import eth_rx_frame_buffer_pkg::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned FRAME_SLOTS = 32,
  parameter int unsigned LEN_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  eth_rx_bus_t          rx_bus,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [31:0]          rd_data,
  output logic [2:0]           rd_bytes_valid,
  output logic                 rd_last,
  output logic                 rd_first,
  output logic [LEN_WIDTH-1:0] rd_frame_len
`ifdef ETH_RX_FRAME_BUFFER_STATS_EN
  ,
  output logic [31:0]          stat_committed,
  output logic [31:0]          stat_dropped,
  output logic [31:0]          stat_overflow
`endif
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;
  localparam int unsigned LenW1 = LEN_WIDTH + 1;

  logic [34:0]          mem [DEPTH];
  logic [AddrW-1:0]     mem_waddr;
  logic                 mem_we;
  logic [PtrW-1:0]      wr_tmp_q, wr_tmp_d, wr_commit_q, wr_commit_d, rd_ptr_q, fill;
  logic [LEN_WIDTH-1:0] len_acc_q, len_acc_d;
  logic                 ovf_q, ovf_d, open_q, open_d;
  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [LEN_WIDTH-1:0] fifo_len;

  eth_rx_len_fifo #(
    .FRAME_SLOTS(FRAME_SLOTS),
    .LEN_WIDTH  (LEN_WIDTH)
  ) u_len_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (fifo_push),
    .data_i (len_acc_d),
    .pop_i  (fifo_pop),
    .data_o (fifo_len),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // Bus fields are applied in order start, data, commit, drop within one cycle.
  always_comb begin
    wr_tmp_d    = wr_tmp_q;
    wr_commit_d = wr_commit_q;
    len_acc_d   = len_acc_q;
    ovf_d       = ovf_q;
    open_d      = open_q;
    mem_we      = 1'b0;
    mem_waddr   = wr_tmp_q[AddrW-1:0];
    fifo_push   = 1'b0;
    if (rx_bus.start) begin
      wr_tmp_d  = wr_commit_q;
      len_acc_d = '0;
      ovf_d     = 1'b0;
      open_d    = 1'b1;
    end
    fill = wr_tmp_d - rd_ptr_q;
    if (rx_bus.data_valid && !ovf_d) begin
      if (fill == PtrW'(DEPTH)) begin
        ovf_d = 1'b1;
      end else begin
        mem_we    = 1'b1;
        mem_waddr = wr_tmp_d[AddrW-1:0];
        wr_tmp_d  = wr_tmp_d + 1'b1;
        len_acc_d = len_acc_d + LEN_WIDTH'(rx_bus.bytes_valid);
      end
    end
    if (rx_bus.commit && open_d) begin
      if (!ovf_d && len_acc_d != '0 && !fifo_full) begin
        fifo_push   = 1'b1;
        wr_commit_d = wr_tmp_d;
      end else begin
        wr_tmp_d = wr_commit_q;
      end
      open_d = 1'b0;
    end
    if (rx_bus.drop && open_d) begin
      wr_tmp_d = wr_commit_d;
      open_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= {rx_bus.bytes_valid, rx_bus.data};
  end

  // Read side: fetch pointer runs ahead of rd_ptr through a one-word RAM stage (rv_*).
  rd_state_t            state_q, state_d;
  logic [PtrW-1:0]      fptr_q, fptr_d;
  logic [LEN_WIDTH-1:0] remain_q, remain_d, flen_q, flen_d, new_words, tag_len;
  logic [LenW1-1:0]     len_round;
  logic                 out_free, rv_free, re, tag_first, tag_last;
  logic                 rv_q, rv_first_q, rv_last_q;
  logic [LEN_WIDTH-1:0] rv_len_q;
  logic [34:0]          rdata_q;
  logic                 rd_valid_q, rd_first_q, rd_last_q;
  logic [31:0]          rd_data_q;
  logic [2:0]           rd_bv_q;
  logic [LEN_WIDTH-1:0] rd_len_q;

  assign out_free  = !rd_valid_q || rd_ready;
  assign rv_free   = !rv_q || out_free;
  assign len_round = LenW1'(fifo_len) + LenW1'(RX_WORD_BYTES - 1);
  assign new_words = LEN_WIDTH'(len_round / LenW1'(RX_WORD_BYTES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RdIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RdIdle: if (!fifo_empty && rv_free) state_d = RdFetch;
      RdFetch, RdData: begin
        if (remain_q != '0) begin
          if (rv_free) state_d = RdData;
        end else if (!fifo_empty && rv_free) begin
          state_d = RdFetch;
        end else begin
          state_d = RdIdle;
        end
      end
      default: state_d = RdIdle;
    endcase
  end

  always_comb begin
    fifo_pop = 1'b0;
    re       = 1'b0;
    unique case (state_q)
      RdIdle: fifo_pop = !fifo_empty && rv_free;
      RdFetch, RdData: begin
        if (remain_q != '0) re = rv_free;
        else                fifo_pop = !fifo_empty && rv_free;
      end
      default: ;
    endcase
    if (fifo_pop) re = 1'b1;
  end

  always_comb begin
    remain_d  = remain_q;
    flen_d    = flen_q;
    fptr_d    = fptr_q;
    tag_first = 1'b0;
    tag_last  = 1'b0;
    tag_len   = flen_q;
    if (fifo_pop) begin
      remain_d  = new_words - 1'b1;
      flen_d    = fifo_len;
      tag_first = 1'b1;
      tag_last  = (new_words == LEN_WIDTH'(1));
      tag_len   = fifo_len;
    end else if (re) begin
      remain_d = remain_q - 1'b1;
      tag_last = (remain_q == LEN_WIDTH'(1));
    end
    if (re) fptr_d = fptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (re) rdata_q <= mem[fptr_q[AddrW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_tmp_q    <= '0;
      wr_commit_q <= '0;
      len_acc_q   <= '0;
      ovf_q       <= 1'b0;
      open_q      <= 1'b0;
      rd_ptr_q    <= '0;
      fptr_q      <= '0;
      remain_q    <= '0;
      flen_q      <= '0;
      rv_q        <= 1'b0;
      rv_first_q  <= 1'b0;
      rv_last_q   <= 1'b0;
      rv_len_q    <= '0;
      rd_valid_q  <= 1'b0;
      rd_first_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_data_q   <= '0;
      rd_bv_q     <= '0;
      rd_len_q    <= '0;
    end else begin
      wr_tmp_q    <= wr_tmp_d;
      wr_commit_q <= wr_commit_d;
      len_acc_q   <= len_acc_d;
      ovf_q       <= ovf_d;
      open_q      <= open_d;
      fptr_q      <= fptr_d;
      remain_q    <= remain_d;
      flen_q      <= flen_d;
      if (rd_valid_q && rd_ready) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (re) begin
        rv_q       <= 1'b1;
        rv_first_q <= tag_first;
        rv_last_q  <= tag_last;
        rv_len_q   <= tag_len;
      end else if (out_free) begin
        rv_q <= 1'b0;
      end
      if (out_free) begin
        rd_valid_q <= rv_q;
        if (rv_q) begin
          rd_data_q  <= rdata_q[31:0];
          rd_bv_q    <= rdata_q[34:32];
          rd_first_q <= rv_first_q;
          rd_last_q  <= rv_last_q;
          rd_len_q   <= rv_len_q;
        end
      end
    end
  end

  assign rd_valid       = rd_valid_q;
  assign rd_data        = rd_data_q;
  assign rd_bytes_valid = rd_bv_q;
  assign rd_first       = rd_first_q;
  assign rd_last        = rd_last_q;
  assign rd_frame_len   = rd_len_q;

`ifdef ETH_RX_FRAME_BUFFER_STATS_EN
  logic        open_mid;
  logic [31:0] stat_committed_q, stat_dropped_q, stat_overflow_q;

  // Frame open when commit/drop are evaluated, i.e. after this cycle's start.
  assign open_mid = rx_bus.start || open_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_committed_q <= '0;
      stat_dropped_q   <= '0;
      stat_overflow_q  <= '0;
    end else begin
      if (fifo_push && stat_committed_q != '1) stat_committed_q <= stat_committed_q + 1'b1;
      if (rx_bus.commit && open_mid && !fifo_push && stat_overflow_q != '1) begin
        stat_overflow_q <= stat_overflow_q + 1'b1;
      end
      if (rx_bus.drop && open_mid && !rx_bus.commit && stat_dropped_q != '1) begin
        stat_dropped_q <= stat_dropped_q + 1'b1;
      end
    end
  end

  assign stat_committed = stat_committed_q;
  assign stat_dropped   = stat_dropped_q;
  assign stat_overflow  = stat_overflow_q;
`endif

endmodule

// File: tb/tb_eth_rx_frame_buffer.sv
// Scoreboard bench for eth_rx_frame_buffer (DEPTH=64): driver queues expected words, monitor checks.
module tb_eth_rx_frame_buffer;
  import eth_rx_frame_buffer_pkg::*;

  localparam int ActNone = 0, ActCommit = 1, ActDrop = 2;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  bv;
    logic        first;
    logic        last;
    logic [15:0] len;
  } word_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  eth_rx_bus_t rx_bus = '0;
  logic        rd_valid, rd_ready, rd_last, rd_first;
  logic [31:0] rd_data;
  logic [2:0]  rd_bytes_valid;
  logic [15:0] rd_frame_len;
`ifdef ETH_RX_FRAME_BUFFER_STATS_EN
  logic [31:0] stat_committed, stat_dropped, stat_overflow;
`endif

  int    vectors = 0;
  int    miscompares = 0;
  word_t sb[$];
  int    mode = 0;  // 0 ready low, 1 ready high, 2 ready toggles
  bit    bubble_chk = 1'b0;
  bit    have_prev = 1'b0;
  int    gap = 0;

  eth_rx_frame_buffer #(
    .DEPTH      (64),
    .FRAME_SLOTS(8),
    .LEN_WIDTH  (16)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_bus        (rx_bus),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .rd_data       (rd_data),
    .rd_bytes_valid(rd_bytes_valid),
    .rd_last       (rd_last),
    .rd_first      (rd_first),
    .rd_frame_len  (rd_frame_len)
`ifdef ETH_RX_FRAME_BUFFER_STATS_EN
    ,
    .stat_committed(stat_committed),
    .stat_dropped  (stat_dropped),
    .stat_overflow (stat_overflow)
`endif
  );

  initial forever #5 clk = ~clk;

  initial begin
    bit tog;
    tog = 1'b0;
    rd_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tog = ~tog;
      rd_ready = (mode == 1) || (mode == 2 && tog);
    end
  end

  // Monitor: a word is taken when rd_valid && rd_ready at the negedge before the active edge.
  initial begin
    word_t got, exp, held;
    bit stall_prev;
    stall_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      got = {rd_data, rd_bytes_valid, rd_first, rd_last, rd_frame_len};
      if (!rst_n) begin
        stall_prev = 1'b0;
        have_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          vectors++;
          if (!rd_valid || got !== held) begin
            miscompares++;
            $display("FAIL hold: got valid=%b word=%h, required valid=1 word=%h", rd_valid, got, held);
          end
        end
        if (rd_valid && rd_ready) begin
          vectors++;
          if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_word: got %h, required no output", got);
          end else begin
            exp = sb.pop_front();
            if (got !== exp) begin
              miscompares++;
              $display("FAIL word: got data=%h bv=%0d first=%b last=%b len=%0d, required data=%h bv=%0d first=%b last=%b len=%0d",
                       got.data, got.bv, got.first, got.last, got.len,
                       exp.data, exp.bv, exp.first, exp.last, exp.len);
            end
          end
          if (bubble_chk && have_prev) begin
            vectors++;
            if (gap > (got.first ? 1 : 0)) begin
              miscompares++;
              $display("FAIL bubble: got %0d idle cycles, required at most %0d", gap, got.first ? 1 : 0);
            end
          end
          have_prev = 1'b1;
          gap = 0;
        end else if (rd_ready && !rd_valid) begin
          gap++;
        end
        stall_prev = rd_valid && !rd_ready;
        held = got;
      end
    end
  end

  task automatic send_frame(input int nbytes, input logic [15:0] tag, input logic [31:0] last_data,
                            input int act, input bit expect_out);
    int    nw;
    word_t tmpq[$];
    word_t w;
    nw = (nbytes + 3) / 4;
    for (int i = 0; i < nw; i++) begin
      @(posedge clk);
      #1;
      w.bv    = (i == nw - 1 && nbytes % 4 != 0) ? 3'(nbytes % 4) : 3'd4;
      w.data  = (i == nw - 1 && last_data != 0) ? last_data : {tag, 16'(i)};
      w.first = (i == 0);
      w.last  = (i == nw - 1);
      w.len   = 16'(nbytes);
      rx_bus = '0;
      rx_bus.start       = (i == 0);
      rx_bus.data_valid  = 1'b1;
      rx_bus.bytes_valid = w.bv;
      rx_bus.data        = w.data;
      tmpq.push_back(w);
    end
    @(posedge clk);
    #1;
    rx_bus = '0;
    rx_bus.commit = (act == ActCommit);
    rx_bus.drop   = (act == ActDrop);
    if (expect_out) foreach (tmpq[k]) sb.push_back(tmpq[k]);
    @(posedge clk);
    #1;
    rx_bus = '0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || rd_valid) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain_%s: got %0d words undelivered, required 0", name, sb.size());
    end
  endtask

  initial begin
    int lat;
    #1 rst_n = 1'b0;
    #2;
    vectors++;
    if ({rd_valid, rd_first, rd_last, rd_data, rd_bytes_valid, rd_frame_len} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got valid=%b data=%h len=%0d, required all zero", rd_valid, rd_data, rd_frame_len);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    vectors++;
    if (rd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got rd_valid=%b, required 0", rd_valid);
    end

    // 1: 64-byte frame, idle reader, latency from commit cycle
    mode = 1;
    send_frame(64, 16'h0001, 32'h0, ActCommit, 1'b1);
    lat = 1;
    while (!rd_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    vectors++;
    if (lat != 3) begin
      miscompares++;
      $display("FAIL latency: got %0d clocks, required 3", lat);
    end
    wait_drain("t1");

    // 2: 61-byte frame, short last word
    send_frame(61, 16'h0002, 32'hAB00_0000, ActCommit, 1'b1);
    wait_drain("t2");

    // 3: dropped frame then committed frame
    send_frame(20, 16'h00A0, 32'h0, ActDrop, 1'b0);
    send_frame(60, 16'h00B0, 32'h0, ActCommit, 1'b1);
    wait_drain("t3");

    // 4: oversize frame overflows and is discarded; next frame survives
    mode = 0;
    send_frame(300, 16'h0300, 32'h0, ActCommit, 1'b0);
    send_frame(64, 16'h0400, 32'h0, ActCommit, 1'b1);
    repeat (4) @(posedge clk);
`ifdef ETH_RX_FRAME_BUFFER_STATS_EN
    vectors++;
    if (stat_overflow !== 32'd1) begin
      miscompares++;
      $display("FAIL stat_overflow: got %0d, required 1", stat_overflow);
    end
`endif
    mode = 1;
    wait_drain("t4");

    // 5a: back-to-back frames, ready toggling
    mode = 2;
    send_frame(40, 16'h0500, 32'h0, ActCommit, 1'b1);
    send_frame(23, 16'h0501, 32'h0, ActCommit, 1'b1);
    mode = 1;
    wait_drain("t5a");

    // 5b: two queued frames streamed with ready held high
    mode = 0;
    send_frame(28, 16'h0510, 32'h0, ActCommit, 1'b1);
    send_frame(17, 16'h0511, 32'h0, ActCommit, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    have_prev = 1'b0;
    bubble_chk = 1'b1;
    mode = 1;
    wait_drain("t5b");
    bubble_chk = 1'b0;

    // 6: reset mid-read
    send_frame(64, 16'h0600, 32'h0, ActCommit, 1'b1);
    lat = 0;
    while (sb.size() > 10 && lat < 100) begin
      @(posedge clk);
      lat++;
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (rd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got rd_valid=%b, required 0", rd_valid);
    end
    sb.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    vectors++;
    if (rd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL empty_after_reset: got rd_valid=%b, required 0", rd_valid);
    end
    send_frame(24, 16'h0700, 32'h0, ActCommit, 1'b1);
    wait_drain("t6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
